team_06_i2s_tx: RTL and testbench

Parametrised stereo I2S transmitter that replaces the fixed 16-bit mono serializer in the audio output path. It accepts left/right sample pairs over a valid/ready handshake into a one-entry holding buffer, generates its own bit clock (bclk) and word-select clock (lrclk) from the system clock, and shifts each frame out MSB-first in Philips I2S format to the external DAC. Underruns are flagged, and the replacement data sent on an underrun is build-selectable.

---
 rtl/team_06_i2s_tx.sv | 212 +++++++++++++++++++++
 tb/tb_team_06_i2s_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_i2s_tx.sv
// -----------------------------------------------------------------------------
// team_06_i2s_tx
//
// Stereo I2S (Philips format) transmitter. A left/right sample pair is taken
// over a valid/ready handshake into a one-entry holding buffer. The block
// divides clk down to its own bit clock (bclk) and word select (lrclk) and
// shifts each frame out MSB-first, one bclk after the lrclk edge. When a frame
// boundary arrives with no buffered pair, underrun pulses and a fill frame is
// sent instead.
//
// Build option:
//   TEAM06_I2S_TX_UNDERRUN_REPEAT_EN  undefined: underrun fill is silence.
//                                     defined:   underrun fill repeats the
//                                                last frame that was loaded.
//
// Parameters:
//   DATA_W   sample width per channel (8..32)
//   SLOT_W   bclk periods per channel slot (>= DATA_W)
//   CLK_DIV  clk cycles per bclk period (even, >= 2)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        run (1) / stop (0) the serializer; buffer stays live when 0
//   sample_l/_r   left/right sample, two's complement
//   sample_valid  sample pair presented
//   sample_ready  holding buffer empty
//   bclk          registered bit clock, 50% duty
//   lrclk         registered word select, 0 = left slot, 1 = right slot
//   sdata         registered serial data, changes on bclk falling edges
//   underrun      one-clk pulse when a frame loads from an empty buffer
// -----------------------------------------------------------------------------
module team_06_i2s_tx #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DC_W    = $clog2(CLK_DIV);
  localparam int FB_W    = $clog2(FRAME_W);

  localparam logic [DC_W-1:0] DC_MID  = DC_W'(CLK_DIV / 2 - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(CLK_DIV - 1);
  localparam logic [FB_W-1:0] FB_SLOT = FB_W'(SLOT_W);
  localparam logic [FB_W-1:0] FB_LAST = FB_W'(FRAME_W - 1);

  // Frame image in transmission order from bit FRAME_W-1 down: left sample
  // MSB-first padded with zeros to the slot, then the right sample likewise.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [DATA_W-1:0] l,
                                                    input logic [DATA_W-1:0] r);
    logic [SLOT_W-1:0] slot_l;
    logic [SLOT_W-1:0] slot_r;
    slot_l = SLOT_W'(l) << (SLOT_W - DATA_W);
    slot_r = SLOT_W'(r) << (SLOT_W - DATA_W);
    return {slot_l, slot_r};
  endfunction

  logic [DC_W-1:0]    dc_q, dc_d;
  logic [FB_W-1:0]    fb_q, fb_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  buf_l_q, buf_l_d;
  logic [DATA_W-1:0]  buf_r_q, buf_r_d;

  logic               fe;
  logic               load_now;
  logic               accept;
  logic [FRAME_W-1:0] fill_frame;

`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
  logic [DATA_W-1:0]  last_l_q, last_l_d;
  logic [DATA_W-1:0]  last_r_q, last_r_d;
  assign fill_frame = pack_frame(last_l_q, last_r_q);
`else
  // Without repeat the last-frame register is unobservable, so it is not built.
  assign fill_frame = '0;
`endif

  // Falling-edge event: the clk edge on which bclk clears.
  assign fe       = enable && (dc_q == DC_LAST);
  assign load_now = fe && (fb_q == '0);
  assign accept   = sample_valid && !buf_full_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    dc_d       = dc_q;
    fb_d       = fb_q;
    shift_d    = shift_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
    last_l_d   = last_l_q;
    last_r_d   = last_r_q;
`endif

    if (!enable) begin
      // Stopping abandons the frame; the next start begins at fb = 0 with an
      // empty shift register, so the first fb = 0 bit is 0.
      dc_d    = '0;
      fb_d    = '0;
      shift_d = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
    end else begin
      dc_d = fe ? '0 : dc_q + DC_W'(1);
      if (dc_q == DC_MID) begin
        bclk_d = 1'b1;
      end
      if (fe) begin
        bclk_d  = 1'b0;
        fb_d    = (fb_q == FB_LAST) ? '0 : fb_q + FB_W'(1);
        lrclk_d = (fb_q >= FB_SLOT);
        // At fb = 0 this emits the last right-slot bit of the previous frame,
        // which gives the one-bclk delay between lrclk and the MSB.
        sdata_d = shift_q[FRAME_W-1];
        if (load_now) begin
          underrun_d = !buf_full_q;
          shift_d    = buf_full_q ? pack_frame(buf_l_q, buf_r_q) : fill_frame;
        end else begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end
      end
    end

    // Holding buffer. Accept and consume never coincide: accept needs the
    // buffer empty, consume needs it full.
    if (load_now && buf_full_q) begin
      buf_full_d = 1'b0;
`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
      last_l_d   = buf_l_q;
      last_r_d   = buf_r_q;
`endif
    end else if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = sample_l;
      buf_r_d    = sample_r;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_q       <= '0;
      fb_q       <= '0;
      shift_q    <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else begin
      dc_q       <= dc_d;
      fb_q       <= fb_d;
      shift_q    <= shift_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
    end
  end

`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
  // NOTE: the last-frame data registers are reset, not left free, because an
  // underrun before any load must send silence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end
`endif

  assign sample_ready = !buf_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_team_06_i2s_tx
//
// Bench for team_06_i2s_tx. Instance dut runs the default parameters against
// a bit-stream model (cycle count since enable -> bclk phase, fe index -> frame
// bit); instance dut_b (DATA_W=24, SLOT_W=32) is checked with literal values.
// -----------------------------------------------------------------------------
module tb_team_06_i2s_tx;

  localparam int D = 4;
  localparam int S = 16;
  localparam int W = 16;
  localparam int F = 2 * S;

  localparam int W_B = 24;
  localparam int S_B = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         enable = 1'b0;
  logic         sample_valid = 1'b0;
  logic [W-1:0] sample_l = '0;
  logic [W-1:0] sample_r = '0;
  logic         sample_ready, bclk, lrclk, sdata, underrun;

  logic           en_b = 1'b0;
  logic           valid_b = 1'b0;
  logic [W_B-1:0] l_b = '0;
  logic [W_B-1:0] r_b = '0;
  logic           ready_b, bclk_b, lrclk_b, sdata_b, underrun_b;

  team_06_i2s_tx #(.DATA_W(W), .SLOT_W(S), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .underrun(underrun)
  );

  team_06_i2s_tx #(.DATA_W(W_B), .SLOT_W(S_B), .CLK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b),
    .sample_l(l_b), .sample_r(r_b), .sample_valid(valid_b),
    .sample_ready(ready_b), .bclk(bclk_b), .lrclk(lrclk_b),
    .sdata(sdata_b), .underrun(underrun_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: frames as bit arrays in transmission order.
  // ---------------------------------------------------------------------------
  int           m_n;
  logic [0:F-1] m_cur;
  bit           m_full;
  logic [W-1:0] m_l, m_r, m_last_l, m_last_r;
  logic         e_bclk, e_lr, e_sd, e_ur;
  bit           m_fe_now;
  int           m_fb_now;

  function automatic logic [0:F-1] build(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [0:F-1] f;
    logic [W-1:0] s;
    int pos;
    for (int i = 0; i < F; i++) begin
      s    = (i < S) ? l : r;
      pos  = i % S;
      f[i] = (pos < W) ? s[W-1-pos] : 1'b0;
    end
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_cur = '0; m_full = 0;
        m_l = '0; m_r = '0; m_last_l = '0; m_last_r = '0;
        e_bclk = 0; e_lr = 0; e_sd = 0; e_ur = 0;
        m_fe_now = 0; m_fb_now = 0;
      end else begin
        bit acc;
        bit consumed;
        int fb;
        acc = sample_valid && !m_full;
        consumed = 0;
        e_ur = 0;
        m_fe_now = 0;
        if (!enable) begin
          m_n = 0; m_cur = '0;
          e_bclk = 0; e_lr = 0; e_sd = 0;
        end else begin
          m_n++;
          e_bclk = (m_n % D) >= D / 2;
          if (m_n % D == 0) begin
            fb = (m_n / D - 1) % F;
            m_fe_now = 1;
            m_fb_now = fb;
            e_lr = (fb >= S);
            if (fb == 0) begin
              e_sd = m_cur[F-1];
              if (m_full) begin
                m_cur = build(m_l, m_r);
                m_last_l = m_l; m_last_r = m_r;
                m_full = 0;
                consumed = 1;
              end else begin
                e_ur = 1;
`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
                m_cur = build(m_last_l, m_last_r);
`else
                m_cur = '0;
`endif
              end
            end else begin
              e_sd = m_cur[fb-1];
            end
          end
        end
        if (acc && !consumed) begin
          m_full = 1; m_l = sample_l; m_r = sample_r;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && !rst) begin
        check("bclk", bclk, e_bclk);
        check("lrclk", lrclk, e_lr);
        check("sdata", sdata, e_sd);
        check("underrun", underrun, e_ur);
        check("sample_ready", sample_ready, !m_full);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Wait for the model's next fe with the given frame bit index.
  task automatic wait_fb(input int fb, input string tag);
    bit hit;
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk);
      if (m_fe_now && m_fb_now == fb) hit = 1;
    end
    check({tag, " fe reached"}, hit, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1; enable = 0; sample_valid = 0; en_b = 0; valid_b = 0;
    @(negedge clk);
    rst = 0;
  endtask

  logic [0:31] t1_stream;
  int          ur_cnt, sd_cnt;
  int          ur_t[3];
  logic        sd_b[34];
  logic        lr_b[34];
  logic        ur_b0;
  int          fe_n;
  logic        prev_b;

  initial begin
    t1_stream = {16'b1010010111000011, 16'h0F01};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst bclk", bclk, 0);
    check("rst lrclk", lrclk, 0);
    check("rst sdata", sdata, 0);
    check("rst underrun", underrun, 0);
    check("rst sample_ready", sample_ready, 1);
    rst = 0;
    chk_on = 1;

    // Test 1: one pair, default parameters
    @(negedge clk);
    enable = 1; sample_valid = 1; sample_l = 16'hA5C3; sample_r = 16'h0F01;
    @(negedge clk);
    sample_valid = 0;
    check("t1 accepted ready", sample_ready, 0);
    wait_fb(0, "t1");
    check("t1 sdata fb0", sdata, 0);
    check("t1 lrclk fb0", lrclk, 0);
    for (int k = 1; k < F; k++) begin
      wait_fb(k, "t1");
      check($sformatf("t1 sdata fb%0d", k), sdata, t1_stream[k-1]);
      check($sformatf("t1 lrclk fb%0d", k), lrclk, (k >= 16));
    end
    wait_fb(0, "t1 next");
    check("t1 R lsb at next fb0", sdata, 1);
    check("t1 underrun at next fb0", underrun, 1);
    @(negedge clk);
    check("t1 underrun one clk", underrun, 0);
    for (int k = 1; k < F; k++) begin
      wait_fb(k, "t1 frame2");
`ifdef TEAM06_I2S_TX_UNDERRUN_REPEAT_EN
      check($sformatf("t1 repeat sdata fb%0d", k), sdata, t1_stream[k-1]);
`else
      check($sformatf("t1 silence sdata fb%0d", k), sdata, 0);
`endif
    end

    // Test 2: starved transmitter
    do_reset();
    enable = 1;
    ur_cnt = 0; sd_cnt = 0;
    for (int c = 1; c <= 3 * 128; c++) begin
      @(negedge clk);
      if (underrun) begin
        if (ur_cnt < 3) ur_t[ur_cnt] = c;
        ur_cnt++;
      end
      if (sdata) sd_cnt++;
    end
    check("t2 underrun count", ur_cnt, 3);
    check("t2 first underrun cycle", ur_t[0], 4);
    check("t2 underrun period a", ur_t[1] - ur_t[0], 128);
    check("t2 underrun period b", ur_t[2] - ur_t[1], 128);
    check("t2 sdata silent", sd_cnt, 0);

    // Test 3: back-to-back pushes
    do_reset();
    enable = 1; sample_valid = 1; sample_l = 16'h8001; sample_r = 16'h0002;
    @(negedge clk);
    check("t3 ready after p1", sample_ready, 0);
    sample_l = 16'h4000; sample_r = 16'h8000;
    @(negedge clk);
    check("t3 ready c2", sample_ready, 0);
    @(negedge clk);
    check("t3 ready c3", sample_ready, 0);
    @(negedge clk);
    check("t3 ready after load", sample_ready, 1);
    @(negedge clk);
    check("t3 ready after p2", sample_ready, 0);
    sample_valid = 0;
    wait_fb(1, "t3");
    check("t3 p1 fb1", sdata, 1);
    wait_fb(2, "t3");
    check("t3 p1 fb2", sdata, 0);
    wait_fb(1, "t3");
    check("t3 p2 fb1", sdata, 0);
    wait_fb(2, "t3");
    check("t3 p2 fb2", sdata, 1);

    // Test 4: reset mid-frame
    do_reset();
    enable = 1; sample_valid = 1; sample_l = 16'hA5C3; sample_r = 16'h0F01;
    @(negedge clk);
    sample_valid = 0;
    wait_fb(0, "t4");
    sample_valid = 1; sample_l = 16'h1234; sample_r = 16'h5678;
    @(negedge clk);
    sample_valid = 0;
    check("t4 buffer full", sample_ready, 0);
    wait_fb(10, "t4");
    check("t4 sdata fb10", sdata, 1);
    repeat (2) @(negedge clk);
    check("t4 bclk high pre-rst", bclk, 1);
    #1;
    rst = 1;
    #1;
    check("t4 rst bclk", bclk, 0);
    check("t4 rst lrclk", lrclk, 0);
    check("t4 rst sdata", sdata, 0);
    check("t4 rst underrun", underrun, 0);
    check("t4 rst sample_ready", sample_ready, 1);
    @(negedge clk);
    rst = 0;
    wait_fb(0, "t4 resume");
    check("t4 resume underrun", underrun, 1);
    check("t4 resume sdata", sdata, 0);

    // Test 5: DATA_W = 24, SLOT_W = 32
    do_reset();
    en_b = 1; valid_b = 1; l_b = 24'h800001; r_b = 24'h123456;
    @(negedge clk);
    valid_b = 0;
    fe_n = 0;
    prev_b = bclk_b;
    ur_b0 = 0;
    for (int c = 0; c < 700 && fe_n < 34; c++) begin
      @(negedge clk);
      if (prev_b && !bclk_b) begin
        sd_b[fe_n] = sdata_b;
        lr_b[fe_n] = lrclk_b;
        if (fe_n == 0) ur_b0 = underrun_b;
        fe_n++;
      end
      prev_b = bclk_b;
    end
    check("t5 fe count", fe_n, 34);
    check("t5 underrun fb0", ur_b0, 0);
    check("t5 sdata fb0", sd_b[0], 0);
    check("t5 sdata fb1", sd_b[1], 1);
    check("t5 sdata fb2", sd_b[2], 0);
    check("t5 sdata fb24", sd_b[24], 1);
    for (int k = 25; k <= 32; k++) begin
      check($sformatf("t5 sdata fb%0d", k), sd_b[k], 0);
    end
    check("t5 lrclk fb0", lr_b[0], 0);
    check("t5 lrclk fb31", lr_b[31], 0);
    check("t5 lrclk fb32", lr_b[32], 1);
    check("t5 sdata fb33 R msb", sd_b[33], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
